serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial unsigned subtractor that computes `a - b` one bit per clock, LSB first. It uses a single full-subtractor cell and a borrow flip-flop in place of a WIDTH-bit ripple array. It is the subtract-direction counterpart of the gate-level full adder in the arithmetic library. It sits beside the adders as a low-area datapath unit driven by a simple start/done handshake.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal values are ≥ 1.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `start`  in  1: request a subtraction; sampled only when `busy` = 0.
- `a`  in  WIDTH: minuend, captured on the accepting edge.
- `b`  in  WIDTH: subtrahend, captured on the accepting edge.
- `busy`  out  1: operation in progress; `start` is ignored while high.
- `done`  out  1: single-cycle pulse; `diff` and `bout` are newly valid.
- `diff`  out  WIDTH: `(a - b) mod 2^WIDTH` of the last completed operation.
- `bout`  out  1: final borrow; 1 iff `a < b` (unsigned) for the last completed operation.

## Operation
- Internal state:
  - operand shift registers `sa` and `sb`, each WIDTH bits, shifting right;
  - result shift register `sd`;
  - borrow flop `br`;
  - bit counter `cnt`, width `clog2(WIDTH+1)`, minimum 1;
  - FSM with states IDLE, RUN, DONE.
- Per-bit cell, with `x = sa[0]`, `y = sb[0]`, `c = br`:
  - `d = x ^ y ^ c`
  - `bnext = (~x & y) | (~(x ^ y) & c)`
  - `d` shifts into the MSB of `sd`; `br <= bnext`.
- FSM transitions:
  - IDLE → RUN on `start` = 1: load `sa <= a`, `sb <= b`, `br <= 0`, `cnt <= 0`.
  - RUN: process one bit per edge and increment `cnt`. On the edge that processes bit WIDTH-1:
    - copy the final `sd` (including that bit) to `diff`;
    - copy `bnext` to `bout`;
    - go to DONE.
  - DONE → IDLE when `start` = 0.
  - DONE → RUN when `start` = 1 (back-to-back accept); the load happens exactly as from IDLE.
- `busy` = 1 in RUN only. `done` = 1 in DONE only.
- `diff` and `bout` hold their value from completion until the next completion. They never show partial results.
- Arithmetic is unsigned modulo 2^WIDTH. There is no overflow flag beyond `bout`.
- `a` and `b` may change freely after the accepting edge; they are not re-sampled.

## Timing
- Reset: while `rst` = 1 on an edge:
  - state goes to IDLE;
  - `busy` = 0, `done` = 0, `diff` = 0, `bout` = 0;
  - `sa`, `sb`, `sd`, `br`, `cnt` are cleared.
- `rst` has priority over `start` and over any in-flight operation. Reset mid-RUN aborts the operation with no `done` and leaves outputs at 0.
- Latency, with `start` accepted at edge E0:
  - `busy` is high from after E0 until after E(WIDTH);
  - bits 0..WIDTH-1 are processed at edges E1..E(WIDTH);
  - `done` is high for exactly the cycle between E(WIDTH) and E(WIDTH+1);
  - `diff` and `bout` change at E(WIDTH).
- Throughput: one result per WIDTH+1 cycles with continuous `start`. The DONE cycle doubles as the accept cycle.
- `start` asserted during RUN is dropped. It is not queued.
- WIDTH = 1: RUN lasts one edge and `done` follows at E2. The counter still works at its minimum width of 1.

## Test plan
- WIDTH=8, reset then pulse `start` with a=0x5A, b=0x23 → `busy` high for 8 cycles; `done` pulses once 9 edges after accept; `diff`=0x37, `bout`=0.
- a=0x00, b=0x01 → `diff`=0xFF, `bout`=1; then a=0xA5, b=0xA5 → `diff`=0x00, `bout`=0; then a=0xFF, b=0x00 → `diff`=0xFF, `bout`=0.
- Busy and result hold:
  - hold `start`=1 throughout with a=0x10, b=0x01;
  - change a/b to 0x00/0xFF during RUN;
  - required: first result `diff`=0x0F, `bout`=0; the next operation is accepted in the DONE cycle and returns `diff`=0x01, `bout`=1;
  - between completions, `diff`/`bout` stay constant.
- Reset abort: assert `rst` for one cycle at the 4th cycle of RUN after a successful prior result → `busy`, `done`, `diff`, `bout` all 0 on the next cycle; no `done` pulse for the aborted operation; a fresh a=0x03, b=0x05 then yields `diff`=0xFE, `bout`=1.
- Exhaustive WIDTH=4: all 256 (a, b) pairs back-to-back → each `diff` = (a-b)&0xF and `bout` = (a<b), checked against a reference model; `done` count = 256.
- WIDTH=1: all 4 pairs → (0,0)→0/0, (1,0)→1/0, (0,1)→1/1, (1,1)→0/0, each with `done` 2 edges after accept.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell plus a borrow flop,
// LSB first, with a start/busy/done handshake and held result registers.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sd_q, sd_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             x, y, d_bit, bnext, last;
  logic [WIDTH-1:0] sd_shift;

  assign x        = sa_q[0];
  assign y        = sb_q[0];
  assign d_bit    = x ^ y ^ br_q;
  assign bnext    = (~x & y) | (~(x ^ y) & br_q);
  // Shift form avoids a zero-width slice when WIDTH = 1.
  assign sd_shift = (sd_q >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
  assign last     = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sd_d    = sd_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    unique case (state_q)
      RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        sd_d  = sd_shift;
        br_d  = bnext;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          diff_d  = sd_shift;
          bout_d  = bnext;
          state_d = DONE;
        end
      end
      IDLE, DONE: begin
        // DONE doubles as an accept cycle for back-to-back operation.
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sd_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sd_q    <= sd_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH = 8, 4 and 1.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start8 = 1'b0, busy8, done8, bout8;
  logic [7:0] a8 = '0, b8 = '0, diff8;
  logic       start4 = 1'b0, busy4, done4, bout4;
  logic [3:0] a4 = '0, b4 = '0, diff4;
  logic       start1 = 1'b0, busy1, done1, bout1;
  logic [0:0] a1 = '0, b1 = '0, diff1;

  int nvec = 0;
  int nerr = 0;
  int ndone4 = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8));
  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4));
  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1));

  always @(posedge clk) if (done4 === 1'b1) ndone4 <= ndone4 + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // From just after the accept edge, wait for done (bounded) and check hold/result.
  task automatic wait8(input logic [7:0] hd, input logic hb,
                       input logic [7:0] ed, input logic eb);
    int lat = 0;
    do begin
      @(posedge clk); #1; lat++;
      if (done8 !== 1'b1) begin
        chk("busy_run", busy8, 1);
        chk("diff_hold", diff8, hd);
        chk("bout_hold", bout8, hb);
      end
    end while (done8 !== 1'b1 && lat < 20);
    chk("latency8", lat, 8);
    chk("diff8", diff8, ed);
    chk("bout8", bout8, eb);
    chk("busy_in_done", busy8, 0);
  endtask

  task automatic op8(input logic [7:0] av, input logic [7:0] bv,
                     input logic [7:0] hd, input logic hb,
                     input logic [7:0] ed, input logic eb);
    a8 = av; b8 = bv; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    chk("busy_after_accept", busy8, 1);
    chk("done_after_accept", done8, 0);
    wait8(hd, hb, ed, eb);
    @(posedge clk); #1;
    chk("done_single", done8, 0);
    chk("busy_idle", busy8, 0);
    chk("diff_keep", diff8, ed);
  endtask

  initial begin
    logic [7:0] nxt;
    logic [3:0] ca, cb;
    logic [1:0] pr;
    int lat;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy8", busy8, 0); chk("rst_done8", done8, 0);
    chk("rst_diff8", diff8, 0); chk("rst_bout8", bout8, 0);
    chk("rst_busy4", busy4, 0); chk("rst_diff4", diff4, 0);
    chk("rst_busy1", busy1, 0); chk("rst_diff1", diff1, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic vectors
    op8(8'h5A, 8'h23, 8'h00, 1'b0, 8'h37, 1'b0);
    op8(8'h00, 8'h01, 8'h37, 1'b0, 8'hFF, 1'b1);
    op8(8'hA5, 8'hA5, 8'hFF, 1'b1, 8'h00, 1'b0);
    op8(8'hFF, 8'h00, 8'h00, 1'b0, 8'hFF, 1'b0);

    // start held high; operands change mid-run; back-to-back accept in DONE
    a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'h00; b8 = 8'hFF;
    chk("hold_busy0", busy8, 1);
    wait8(8'hFF, 1'b0, 8'h0F, 1'b0);
    @(posedge clk); #1;
    chk("b2b_busy", busy8, 1);
    chk("b2b_done", done8, 0);
    chk("b2b_diff", diff8, 8'h0F);
    wait8(8'h0F, 1'b0, 8'h01, 1'b1);
    start8 = 1'b0;
    @(posedge clk); #1;
    chk("b2b_end_done", done8, 0);
    chk("b2b_end_diff", diff8, 8'h01);

    // Reset abort during the 4th RUN cycle
    a8 = 8'h77; b8 = 8'h11; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("abort_busy_pre", busy8, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", busy8, 0); chk("abort_done", done8, 0);
    chk("abort_diff", diff8, 0); chk("abort_bout", bout8, 0);
    repeat (12) begin
      @(posedge clk); #1;
      chk("abort_no_done", done8, 0);
      chk("abort_diff_zero", diff8, 0);
    end
    op8(8'h03, 8'h05, 8'h00, 1'b0, 8'hFE, 1'b1);

    // Exhaustive WIDTH=4, back-to-back
    a4 = 4'h0; b4 = 4'h0; start4 = 1'b1;
    @(posedge clk); #1;
    for (int p = 0; p < 256; p++) begin
      if (p > 0) begin
        @(posedge clk); #1;
      end
      chk("w4_busy_accept", busy4, 1);
      nxt = 8'(p);
      ca = nxt[7:4]; cb = nxt[3:0];
      if (p < 255) begin
        nxt = 8'(p + 1);
        a4 = nxt[7:4]; b4 = nxt[3:0];
      end else begin
        start4 = 1'b0;
      end
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (done4 !== 1'b1 && lat < 10);
      chk("w4_latency", lat, 4);
      chk("w4_diff", diff4, 4'((ca - cb) & 4'hF));
      chk("w4_bout", bout4, (ca < cb) ? 1 : 0);
    end
    @(posedge clk); #1;
    chk("w4_done_count", ndone4, 256);
    chk("w4_idle", busy4, 0);

    // WIDTH=1, all pairs
    for (int p = 0; p < 4; p++) begin
      pr = 2'(p);
      a1 = pr[0]; b1 = pr[1]; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      chk("w1_busy", busy1, 1);
      chk("w1_done_early", done1, 0);
      @(posedge clk); #1;
      chk("w1_done", done1, 1);
      chk("w1_diff", diff1, pr[0] ^ pr[1]);
      chk("w1_bout", bout1, (!pr[0] && pr[1]) ? 1 : 0);
      @(posedge clk); #1;
      chk("w1_done_drop", done1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
